// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush, used both as the instruction buffer and as the
// queue of PC tags for outstanding memory requests. Depth must be a power of two >= 2.
module ifu_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned     PtrW = $clog2(Depth);
    localparam int unsigned     CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] Full = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Flush wins over push/pop; a pop already handed to the reader is simply discarded
    assign do_push = push_i && !flush_i && (count_q != Full);
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Pointer and occupancy next state
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrW'(1);
            if (do_pop)  rptr_d = rptr_q + PtrW'(1);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; entries are only observed while counted valid
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order word fetches under a credit limit,
// tags each request with its PC and buffers returned words for decode. Redirects flush all
// buffered state and mark outstanding responses for discard.
// Optional build macro IFU_MISALIGN_CHECK_EN: a misaligned redirect raises fetch_fault and
// halts fetching until the next aligned redirect; otherwise target bits [1:0] are ignored.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i,
    output logic            fetch_fault_o
);

    localparam int unsigned   CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned   DropW  = 16;
    localparam logic [CntW:0] Credit = (CntW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [DropW-1:0] drop_q, drop_d;
    logic [CntW-1:0]  inflight;    // PC queue occupancy == requests awaiting a kept response
    logic [CntW-1:0]  fifo_count;
    logic [XLEN-1:0]  tag_pc;
    logic [XLEN-1:0]  redirect_tgt;
    fetch_entry_t     rsp_entry, head;
    logic             req_fire, rsp_keep, out_fire, halted;

`ifdef IFU_MISALIGN_CHECK_EN
    logic halted_q, halted_d;

    assign halted        = halted_q;
    assign redirect_tgt  = redirect_pc_i;
    assign fetch_fault_o = halted_q;   // fault and halt always set and clear together

    // Only a redirect can enter or leave the halted state
    always_comb begin
        halted_d = halted_q;
        if (redirect_i) halted_d = |redirect_pc_i[1:0];
    end

    // Halt/fault register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) halted_q <= 1'b0;
        else         halted_q <= halted_d;
    end
`else
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign halted        = 1'b0;
    assign redirect_tgt  = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign fetch_fault_o = 1'b0;
`endif

    // Reset gates the request so nothing is offered to memory while rst_ni is low
    assign imem_req_valid_o = rst_ni && !halted && (({1'b0, inflight} + {1'b0, fifo_count}) < Credit);
    assign imem_req_addr_o  = pc_q;

    assign req_fire  = imem_req_valid_o && imem_req_ready_i;
    assign rsp_keep  = imem_rsp_valid_i && !redirect_i && (drop_q == '0);
    assign out_fire  = inst_valid_o && inst_ready_i;
    assign rsp_entry = '{pc: tag_pc, inst: imem_rsp_data_i};

    assign inst_valid_o = (fifo_count != '0);
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_pc_o    = inst_valid_o ? head.pc : RESET_PC;

    ifu_fifo #(
        .Width (XLEN),
        .Depth (FIFO_DEPTH)
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (rsp_keep),
        .data_o  (tag_pc),
        .count_o (inflight)
    );

    ifu_fifo #(
        .Width ($bits(fetch_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (rsp_keep),
        .data_i  (rsp_entry),
        .pop_i   (out_fire),
        .data_o  (head),
        .count_o (fifo_count)
    );

    // PC advance and stale-response accounting; a redirect moves every outstanding
    // request (including one accepted this cycle) into drop, less a response arriving now
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_i) begin
            pc_d   = redirect_tgt;
            drop_d = drop_q + DropW'(inflight) + DropW'(req_fire) - DropW'(imem_rsp_valid_i);
        end else begin
            if (req_fire) pc_d = pc_q + PC_STEP;
            if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    // PC and drop counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a per-cycle vector table for the start-up stream,
// then hand-written sequences for stall, redirects, PC wrap, mid-run reset and misalignment.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_deliv  = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic        mem_en   = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_addr_o  (imem_req_addr),
        .imem_req_ready_i (imem_req_ready),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .inst_ready_i     (inst_ready),
        .fetch_fault_o    (fetch_fault)
    );

    // Memory model: in order, answers one cycle after acceptance with data = ~addr
    logic [31:0] mq[$];
    logic        acc, took;
    logic [31:0] acc_addr;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            took     = imem_rsp_valid;
            @(posedge clk);
            #2;
            if (took && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back(acc_addr);
            if (!rst_ni) mq.delete();
            if (mem_en && mq.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mq[0];
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample point: checks every delivered word against the expected in-order PC stream
    task automatic neg();
        @(negedge clk);
        if (rst_ni && inst_valid && inst_ready) begin
            check("deliver_pc", inst_pc, exp_pc);
            check("deliver_inst", inst, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        neg();
        pos();
    endtask

    typedef struct {
        logic        inst_ready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];
    int   d0;
    logic found;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start-up stream with memory always ready and 1-cycle response
        vecs[0] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        vecs[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h0};

        rst_ni         = 1'b1;
        imem_req_ready = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        #1;
        rst_ni = 1'b0;

        repeat (3) cyc();
        neg();
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'h0);
        pos();
        rst_ni = 1'b1;
        exp_pc = 32'h0;

        for (int i = 0; i < 8; i++) begin
            inst_ready = vecs[i].inst_ready;
            neg();
            check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv)
                check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_inst", i), inst, ~vecs[i].exp_pc);
            end
            pos();
        end

        // Consumer stall: buffer fills, nothing left in flight, requests stop
        inst_ready = 1'b0;
        repeat (10) cyc();
        neg();
        check("stall_req_valid", 32'(imem_req_valid), 32'h0);
        check("stall_inst_valid", 32'(inst_valid), 32'h1);
        check("stall_no_rsp_pending", 32'(imem_rsp_valid), 32'h0);
        pos();
        d0         = n_deliv;
        inst_ready = 1'b1;
        repeat (12) cyc();
        check("stall_release_count", 32'(n_deliv - d0 >= 6), 32'h1);

        // Redirect with two requests in flight
        mem_en = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            neg();
            if (!imem_req_valid && !inst_valid) found = 1'b1;
            pos();
        end
        check("wait_two_inflight", 32'(found), 32'h1);
        check("two_inflight", mq.size(), 32'd2);
        mem_en      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        exp_pc   = 32'h100;
        neg();
        check("redir_req_addr", imem_req_addr, 32'h100);
        check("redir_req_valid", 32'(imem_req_valid), 32'h1);
        check("redir_inst_valid", 32'(inst_valid), 32'h0);
        pos();
        d0 = n_deliv;
        repeat (10) cyc();
        check("redir_count", 32'(n_deliv - d0 >= 4), 32'h1);

        // Redirect in a cycle that also has a response and an output handshake
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            neg();
            if (imem_req_valid && !inst_valid && imem_rsp_valid) found = 1'b1;
            pos();
        end
        check("wait_coinc", 32'(found), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        d0          = n_deliv;
        neg();
        check("coinc_setup", 32'(inst_valid && inst_ready && imem_rsp_valid), 32'h1);
        pos();
        redirect = 1'b0;
        exp_pc   = 32'h300;
        check("coinc_delivered_once", 32'(n_deliv - d0), 32'h1);
        neg();
        check("coinc_inst_valid", 32'(inst_valid), 32'h0);
        check("coinc_req_addr", imem_req_addr, 32'h300);
        pos();
        d0 = n_deliv;
        repeat (10) cyc();
        check("coinc_count", 32'(n_deliv - d0 >= 4), 32'h1);

        // Back-to-back redirects: last target wins
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        cyc();
        redirect_pc = 32'h500;
        cyc();
        redirect = 1'b0;
        exp_pc   = 32'h500;
        neg();
        check("b2b_req_addr", imem_req_addr, 32'h500);
        check("b2b_inst_valid", 32'(inst_valid), 32'h0);
        pos();
        d0 = n_deliv;
        repeat (10) cyc();
        check("b2b_count", 32'(n_deliv - d0 >= 4), 32'h1);

        // PC wrap from the last word of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        exp_pc   = 32'hFFFF_FFFC;
        neg();
        check("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
        pos();
        neg();
        check("wrap_req_valid", 32'(imem_req_valid), 32'h1);
        check("wrap_req_addr1", imem_req_addr, 32'h0);
        pos();
        d0 = n_deliv;
        repeat (10) cyc();
        check("wrap_count", 32'(n_deliv - d0 >= 4), 32'h1);

        // Reset in the middle of streaming
        rst_ni = 1'b0;
        neg();
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("mid_rst_inst_valid", 32'(inst_valid), 32'h0);
        check("mid_rst_inst", inst, NOP);
        check("mid_rst_inst_pc", inst_pc, 32'h0);
        pos();
        rst_ni = 1'b1;
        exp_pc = 32'h0;
        neg();
        check("post_rst_req_addr", imem_req_addr, 32'h0);
        pos();
        d0 = n_deliv;
        repeat (10) cyc();
        check("post_rst_count", 32'(n_deliv - d0 >= 4), 32'h1);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        neg();
        check("fault_set", 32'(fetch_fault), 32'h1);
        check("fault_req_valid", 32'(imem_req_valid), 32'h0);
        check("fault_inst_valid", 32'(inst_valid), 32'h0);
        pos();
        repeat (4) cyc();
        neg();
        check("fault_hold", 32'(fetch_fault), 32'h1);
        check("fault_hold_req_valid", 32'(imem_req_valid), 32'h0);
        pos();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0;
        exp_pc   = 32'h200;
        neg();
        check("fault_clear", 32'(fetch_fault), 32'h0);
        check("fault_resume_valid", 32'(imem_req_valid), 32'h1);
        check("fault_resume_addr", imem_req_addr, 32'h200);
        pos();
`else
        exp_pc = 32'h100;
        neg();
        check("misalign_no_fault", 32'(fetch_fault), 32'h0);
        check("misalign_req_addr", imem_req_addr, 32'h100);
        pos();
`endif
        d0 = n_deliv;
        repeat (10) cyc();
        check("misalign_count", 32'(n_deliv - d0 >= 4), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
